keypad_scanner: RTL and testbench

- Scans a 4x4 active-low matrix keypad for the calculator and reports debounced key presses as 4-bit codes.
- Sits downstream of the clock divider: the divider's divided output, named newClock at the divider, drives scanClock on this block.
- scanClock is never used as a clock; its rising edge is detected in the CLOCK_50 domain and used as the scan/debounce tick.
- Key codes feed the calculator's input decoder.

---
 rtl/keypad_scanner_if.sv | 31 +++
 rtl/keypad_scanner.sv | 187 ++++++++++++++++++
 tb/tb_keypad_scanner.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/keypad_scanner_if.sv
// Keypad-side bundle of the keypad scanner: matrix row/column lines plus the
// key report outputs that feed the calculator's input decoder.
//   row_in    : keypad rows, active-low, asynchronous to the scanner clock
//   col_out   : column drive, active-low, exactly one bit low
//   key_code  : last accepted key, row*4 + col
//   key_valid : one-cycle pulse per accepted report
//   key_held  : high while the accepted key has not been released
// Modports: slave = scanner side, master = keypad/decoder side.
interface keypad_scanner_if;
    logic [3:0] row_in;
    logic [3:0] col_out;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    modport slave (
        input  row_in,
        output col_out,
        output key_code,
        output key_valid,
        output key_held
    );

    modport master (
        output row_in,
        input  col_out,
        input  key_code,
        input  key_valid,
        input  key_held
    );
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 active-low matrix keypad scanner with debounced press/release.
// The divided scanClock is only sampled: its synchronised rising edge forms a
// one-cycle scan/debounce tick in the CLOCK_50 domain.
// Ports:
//   CLOCK_50  : system clock, all state on its rising edge
//   reset     : synchronous, active-high
//   scanClock : divided clock used only as a tick source
//   kp        : keypad_scanner_if.slave (row_in, col_out, key_code,
//               key_valid, key_held)
// Optional feature macro: KEYPAD_REPEAT_EN enables auto-repeat reports while a
// key is held (every REPEAT_TICKS ticks). Default build has no repeat logic.
module keypad_scanner #(
    parameter int unsigned DEBOUNCE_TICKS = 4,
    parameter int unsigned REPEAT_TICKS   = 50
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    input  logic              scanClock,
    keypad_scanner_if.slave   kp
);

    localparam int unsigned  CNT_W   = 4;
    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_TICKS);

    // Elaboration-time parameter range checks
    if (DEBOUNCE_TICKS < 1 || DEBOUNCE_TICKS > 15) begin : g_bad_debounce
        $error("keypad_scanner: DEBOUNCE_TICKS must be 1..15");
    end
    if (REPEAT_TICKS < 1 || REPEAT_TICKS > 255) begin : g_bad_repeat
        $error("keypad_scanner: REPEAT_TICKS must be 1..255");
    end

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        REPORT   = 2'd2,
        HELD     = 2'd3
    } state_t;

    state_t           state;
    logic [3:0]       row_s1, row_s2;
    logic             sc_s1, sc_s2, sc_prev;
    logic [1:0]       col_idx;
    logic [1:0]       row_idx;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic             tick;
    logic             any_low;
    logic [1:0]       first_low;
    logic             latched_low;

    // Lowest-index low row wins when several rows are pulled down
    function automatic logic [1:0] pick_row(input logic [3:0] r);
        if (!r[0])      return 2'd0;
        else if (!r[1]) return 2'd1;
        else if (!r[2]) return 2'd2;
        else            return 2'd3;
    endfunction

    function automatic logic [3:0] col_drive(input logic [1:0] idx);
        return 4'(~(4'b0001 << idx));
    endfunction

    assign tick        = sc_s2 & ~sc_prev;
    assign any_low     = ~&row_s2;
    assign first_low   = pick_row(row_s2);
    assign latched_low = ~row_s2[row_idx];
    // Saturating increment: the counter never wraps back to zero
    assign cnt_inc     = (cnt == {CNT_W{1'b1}}) ? cnt : cnt + CNT_W'(1);

`ifdef KEYPAD_REPEAT_EN
    localparam int unsigned RPT_W    = 8;
    localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(REPEAT_TICKS);
    logic [RPT_W-1:0] rpt_cnt;
`endif

    // Synchronisers, tick edge detect and scan/debounce FSM
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            row_s1       <= 4'hF;
            row_s2       <= 4'hF;
            sc_s1        <= 1'b0;
            sc_s2        <= 1'b0;
            sc_prev      <= 1'b0;
            state        <= SCAN;
            col_idx      <= 2'd0;
            row_idx      <= 2'd0;
            cnt          <= '0;
            kp.col_out   <= 4'b1110;
            kp.key_code  <= 4'd0;
            kp.key_valid <= 1'b0;
            kp.key_held  <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
            rpt_cnt      <= '0;
`endif
        end else begin
            row_s1       <= kp.row_in;
            row_s2       <= row_s1;
            sc_s1        <= scanClock;
            sc_s2        <= sc_s1;
            sc_prev      <= sc_s2;
            kp.key_valid <= 1'b0;

            case (state)
                SCAN: begin
                    if (tick) begin
                        if (any_low) begin
                            row_idx <= first_low;
                            cnt     <= CNT_W'(1);
                            if (DB_LAST == CNT_W'(1)) begin
                                // Report is issued on entry so key_valid is
                                // high during the REPORT cycle itself
                                kp.key_code  <= {first_low, col_idx};
                                kp.key_valid <= 1'b1;
                                kp.key_held  <= 1'b1;
                                state        <= REPORT;
                            end else begin
                                state <= DEBOUNCE;
                            end
                        end else begin
                            col_idx    <= col_idx + 2'd1;
                            kp.col_out <= col_drive(col_idx + 2'd1);
                        end
                    end
                end

                DEBOUNCE: begin
                    if (tick) begin
                        if (latched_low) begin
                            cnt <= cnt_inc;
                            if (cnt_inc == DB_LAST) begin
                                kp.key_code  <= {row_idx, col_idx};
                                kp.key_valid <= 1'b1;
                                kp.key_held  <= 1'b1;
                                state        <= REPORT;
                            end
                        end else begin
                            cnt   <= '0;
                            state <= SCAN;
                        end
                    end
                end

                REPORT: begin
                    cnt   <= '0;
                    state <= HELD;
`ifdef KEYPAD_REPEAT_EN
                    rpt_cnt <= '0;
`endif
                end

                HELD: begin
                    if (tick) begin
                        if (!latched_low) begin
                            if (cnt_inc == DB_LAST) begin
                                cnt         <= '0;
                                kp.key_held <= 1'b0;
                                col_idx     <= col_idx + 2'd1;
                                kp.col_out  <= col_drive(col_idx + 2'd1);
                                state       <= SCAN;
                            end else begin
                                cnt <= cnt_inc;
                            end
`ifdef KEYPAD_REPEAT_EN
                            rpt_cnt <= '0;
`endif
                        end else begin
                            // A bounce back low restarts release counting
                            cnt <= '0;
`ifdef KEYPAD_REPEAT_EN
                            if (rpt_cnt + RPT_W'(1) == RPT_LAST) begin
                                rpt_cnt      <= '0;
                                kp.key_valid <= 1'b1;
                            end else begin
                                rpt_cnt <= rpt_cnt + RPT_W'(1);
                            end
`endif
                        end
                    end
                end

                default: state <= SCAN;
            endcase
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed self-checking bench for keypad_scanner (DEBOUNCE_TICKS=4,
// REPEAT_TICKS=3). A small keypad model pulls rows low for pressed keys whose
// column is currently driven low.
module tb_keypad_scanner;

    logic        clk;
    logic        reset;
    logic        scan_clock;
    logic [15:0] pressed;
    logic [3:0]  rows;
    int          vectors;
    int          errors;
    int          pulses;
    int          tick_no;
    int          pulse_tick[$];
    logic        prev_valid;

    keypad_scanner_if kp ();

    keypad_scanner #(
        .DEBOUNCE_TICKS(4),
        .REPEAT_TICKS  (3)
    ) dut (
        .CLOCK_50 (clk),
        .reset    (reset),
        .scanClock(scan_clock),
        .kp       (kp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Keypad model: key r*4+c pulls row r low while column c is driven low
    always_comb begin
        rows = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[r*4+c] && !kp.col_out[c]) rows[r] = 1'b0;
    end
    assign kp.row_in = rows;

    // Pulse monitor: counts key_valid pulses and flags back-to-back cycles
    always @(negedge clk) begin
        if (kp.key_valid) begin
            pulses++;
            pulse_tick.push_back(tick_no);
            vectors++;
            if (prev_valid !== 1'b0) begin
                errors++;
                $display("FAIL valid_consecutive: key_valid high 2 cycles, got %b want 0", prev_valid);
            end
        end
        prev_valid = kp.key_valid;
    end

    task automatic do_tick();
        tick_no++;
        @(negedge clk) scan_clock = 1'b1;
        repeat (4) @(negedge clk);
        scan_clock = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk) reset = 1'b1;
        pressed = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        pulses = 0;
        pulse_tick.delete();
    endtask

    task automatic test_reset();
        do_reset();
        vectors++;
        if (kp.col_out !== 4'b1110) begin errors++; $display("FAIL reset_col: got %b want 1110", kp.col_out); end
        vectors++;
        if (kp.key_code !== 4'd0) begin errors++; $display("FAIL reset_code: got %0d want 0", kp.key_code); end
        vectors++;
        if (kp.key_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", kp.key_valid); end
        vectors++;
        if (kp.key_held !== 1'b0) begin errors++; $display("FAIL reset_held: got %b want 0", kp.key_held); end
    endtask

    task automatic test_scan();
        logic [3:0] exp_col [8];
        exp_col = '{4'b1101, 4'b1011, 4'b0111, 4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};
        do_reset();
        for (int k = 0; k < 8; k++) begin
            do_tick();
            vectors++;
            if (kp.col_out !== exp_col[k]) begin
                errors++;
                $display("FAIL scan_col[%0d]: got %b want %b", k, kp.col_out, exp_col[k]);
            end
        end
        vectors++;
        if (pulses !== 0) begin errors++; $display("FAIL scan_no_valid: got %0d pulses want 0", pulses); end
        vectors++;
        if (kp.key_code !== 4'd0) begin errors++; $display("FAIL scan_code: got %0d want 0", kp.key_code); end
    endtask

    // Key 9 (row 2, col 1): detected on tick 2, reported on tick 5
    task automatic test_press_release();
        do_reset();
        pressed[9] = 1'b1;
        repeat (4) do_tick();
        vectors++;
        if (pulses !== 0) begin errors++; $display("FAIL press_early: got %0d pulses want 0", pulses); end
        do_tick();
        vectors++;
        if (pulses !== 1) begin errors++; $display("FAIL press_pulse: got %0d pulses want 1", pulses); end
        vectors++;
        if (kp.key_code !== 4'd9) begin errors++; $display("FAIL press_code: got %0d want 9", kp.key_code); end
        vectors++;
        if (kp.key_held !== 1'b1) begin errors++; $display("FAIL press_held: got %b want 1", kp.key_held); end
        pressed = '0;
        repeat (3) do_tick();
        vectors++;
        if (kp.key_held !== 1'b1) begin errors++; $display("FAIL release_early: got %b want 1", kp.key_held); end
        do_tick();
        vectors++;
        if (kp.key_held !== 1'b0) begin errors++; $display("FAIL release_held: got %b want 0", kp.key_held); end
        vectors++;
        if (kp.col_out !== 4'b1011) begin errors++; $display("FAIL release_col: got %b want 1011", kp.col_out); end
        vectors++;
        if (pulses !== 1) begin errors++; $display("FAIL release_pulses: got %0d want 1", pulses); end
        vectors++;
        if (kp.key_code !== 4'd9) begin errors++; $display("FAIL release_code_hold: got %0d want 9", kp.key_code); end
    endtask

    // Key 3 (row 0, col 3): low, high, low, then stable
    task automatic test_bounce();
        do_reset();
        pressed[3] = 1'b1;
        repeat (4) do_tick();     // ticks 1-3 reach col 3, tick 4 detects
        pressed[3] = 1'b0;
        do_tick();                // bounce high: back to SCAN on col 3
        pressed[3] = 1'b1;
        repeat (3) do_tick();     // new detection + 2 matching ticks
        vectors++;
        if (pulses !== 0) begin errors++; $display("FAIL bounce_early: got %0d pulses want 0", pulses); end
        vectors++;
        if (kp.col_out !== 4'b0111) begin errors++; $display("FAIL bounce_col: got %b want 0111", kp.col_out); end
        do_tick();
        vectors++;
        if (pulses !== 1) begin errors++; $display("FAIL bounce_pulse: got %0d want 1", pulses); end
        vectors++;
        if (kp.key_code !== 4'd3) begin errors++; $display("FAIL bounce_code: got %0d want 3", kp.key_code); end
    endtask

    // Rows 1 and 3 low on col 0: row 1 wins, code 4
    task automatic test_multi_row();
        do_reset();
        pressed[4]  = 1'b1;
        pressed[12] = 1'b1;
        repeat (4) do_tick();
        vectors++;
        if (kp.key_code !== 4'd4) begin errors++; $display("FAIL multi_code: got %0d want 4", kp.key_code); end
        vectors++;
        if (pulses !== 1) begin errors++; $display("FAIL multi_pulse: got %0d want 1", pulses); end
    endtask

    task automatic check_reset_state(input string tag);
        vectors++;
        if (kp.col_out !== 4'b1110 || kp.key_code !== 4'd0 || kp.key_valid !== 1'b0 || kp.key_held !== 1'b0) begin
            errors++;
            $display("FAIL %s: got col=%b code=%0d valid=%b held=%b want col=1110 code=0 valid=0 held=0",
                     tag, kp.col_out, kp.key_code, kp.key_valid, kp.key_held);
        end
    endtask

    task automatic test_reset_midway();
        // Mid-debounce: key 1 (row 0, col 1) detected on tick 2, cnt=2 after tick 3
        do_reset();
        pressed[1] = 1'b1;
        repeat (3) do_tick();
        @(negedge clk) reset = 1'b1;
        @(negedge clk);
        check_reset_state("reset_debounce");
        reset = 1'b0;
        pressed = '0;
        repeat (4) do_tick();
        vectors++;
        if (pulses !== 0) begin errors++; $display("FAIL reset_debounce_pulse: got %0d want 0", pulses); end
        // Mid-hold: key 0 reported on tick 4
        do_reset();
        pressed[0] = 1'b1;
        repeat (5) do_tick();
        vectors++;
        if (kp.key_held !== 1'b1) begin errors++; $display("FAIL hold_before_reset: got %b want 1", kp.key_held); end
        @(negedge clk) reset = 1'b1;
        @(negedge clk);
        check_reset_state("reset_held");
        reset = 1'b0;
        pressed = '0;
    endtask

    // Key 6 (row 1, col 2) held for 10 ticks after its report
    task automatic test_back_to_back();
        int exp_extra;
        do_reset();
        pressed[6] = 1'b1;
        repeat (6) do_tick();     // col 2 after tick 2, detect tick 3, report tick 6
        vectors++;
        if (pulses !== 1 || kp.key_code !== 4'd6) begin
            errors++;
            $display("FAIL hold_first: got pulses=%0d code=%0d want 1 and 6", pulses, kp.key_code);
        end
        repeat (10) do_tick();
`ifdef KEYPAD_REPEAT_EN
        exp_extra = 3;
`else
        exp_extra = 0;
`endif
        vectors++;
        if (pulses - 1 !== exp_extra) begin
            errors++;
            $display("FAIL hold_repeats: got %0d extra pulses want %0d", pulses - 1, exp_extra);
        end
        vectors++;
        if (kp.key_code !== 4'd6 || kp.key_held !== 1'b1) begin
            errors++;
            $display("FAIL hold_state: got code=%0d held=%b want 6 and 1", kp.key_code, kp.key_held);
        end
`ifdef KEYPAD_REPEAT_EN
        if (pulse_tick.size() == 4) begin
            for (int i = 1; i < 4; i++) begin
                vectors++;
                if (pulse_tick[i] - pulse_tick[i-1] !== 3) begin
                    errors++;
                    $display("FAIL repeat_spacing[%0d]: got %0d ticks want 3", i, pulse_tick[i] - pulse_tick[i-1]);
                end
            end
        end
`endif
        pressed = '0;
        repeat (4) do_tick();
        vectors++;
        if (kp.key_held !== 1'b0) begin errors++; $display("FAIL hold_release: got %b want 0", kp.key_held); end
    endtask

    initial begin
        vectors    = 0;
        errors     = 0;
        pulses     = 0;
        tick_no    = 0;
        prev_valid = 1'b0;
        reset      = 1'b1;
        scan_clock = 1'b0;
        pressed    = '0;
        test_reset();
        test_scan();
        test_press_release();
        test_bounce();
        test_multi_row();
        test_reset_midway();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
